// File: rtl/apb_pkg.sv
// Shared APB types: FSM state encoding, the registered command and the
// response record returned to the requester.
package apb_pkg;

   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_DATA_W = 32;

   typedef enum logic [1:0] {
      APB_IDLE,
      APB_SETUP,
      APB_ACCESS
   } apb_state_t;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_cmd_t;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

   // Builds the response for a normal completion: writes return zero data,
   // and the error flag is whatever the completer reported on the last cycle.
   function automatic apb_rsp_t apbCompletion(input logic                  write,
                                              input logic [APB_DATA_W-1:0] prdata,
                                              input logic                  slverr);
      apb_rsp_t rsp;
      rsp.rdata   = write ? '0 : prdata;
      rsp.err     = slverr;
      rsp.timeout = 1'b0;
      return rsp;
   endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// APB requester: accepts one command at a time on a valid/ready port, runs
// the SETUP/ACCESS transfer and holds the response until it is consumed.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES wait-state cycles; otherwise ACCESS waits indefinitely and
// RSP_TIMEOUT is always 0.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_WRITE,
   input  logic [ADDR_W-1:0] CMD_ADDR,
   input  logic [DATA_W-1:0] CMD_WDATA,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [DATA_W-1:0] RSP_RDATA,
   output logic              RSP_ERR,
   output logic              RSP_TIMEOUT,
   output logic              PSELx,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   // The command/response records are sized by the package, so the port
   // widths must agree with them.
   if (ADDR_W != APB_ADDR_W || DATA_W != APB_DATA_W || TIMEOUT_CYCLES < 1) begin : gParamCheck
      $error("apb_master_bridge: unsupported parameter set");
   end

   apb_state_t r_state;
   apb_state_t w_nextState;
   apb_cmd_t   r_cmd;
   apb_rsp_t   r_rsp;
   logic       r_rspValid;
   logic       w_cmdReady;
   logic       w_accept;
   logic       w_complete;
   logic       w_abort;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_waitCnt;
   logic             w_limitHit;

   assign w_limitHit = (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   // Next-state and bus control decode; the bus strobes follow the state
   // directly, and a new command is only taken when nothing is pending.
   always_comb begin
      w_nextState = r_state;
      w_cmdReady  = (r_state == APB_IDLE) && !r_rspValid;
      w_accept    = 1'b0;
      w_complete  = 1'b0;
      w_abort     = 1'b0;
      PSELx       = 1'b0;
      PENABLE     = 1'b0;
      case (r_state)
         APB_IDLE: begin
            if (CMD_VALID && w_cmdReady) begin
               w_accept    = 1'b1;
               w_nextState = APB_SETUP;
            end
         end
         APB_SETUP: begin
            PSELx       = 1'b1;
            w_nextState = APB_ACCESS;
         end
         APB_ACCESS: begin
            PSELx   = 1'b1;
            PENABLE = 1'b1;
            if (PREADY) begin
               w_complete  = 1'b1;
               w_nextState = APB_IDLE;
            end
`ifdef APB_MASTER_TIMEOUT_EN
            else if (w_limitHit) begin
               w_abort     = 1'b1;
               w_nextState = APB_IDLE;
            end
`endif
         end
         default: begin
            w_nextState = APB_IDLE;
         end
      endcase
   end

   // State register; reset drops any transfer in flight without a response.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state <= APB_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Command capture on accept; the bus address/data hold from SETUP through
   // the last ACCESS cycle and keep their last values while idle.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_cmd <= '0;
      end else if (w_accept) begin
         r_cmd <= '{write: CMD_WRITE, addr: CMD_ADDR, wdata: CMD_WDATA};
      end
   end

   // Response holding register: set on completion or abort, cleared by the
   // consumer's handshake. PSLVERR and PRDATA are only sampled at completion.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_rspValid <= 1'b0;
         r_rsp      <= '0;
      end else if (w_complete) begin
         r_rspValid <= 1'b1;
         r_rsp      <= apbCompletion(r_cmd.write, PRDATA, PSLVERR);
      end else if (w_abort) begin
         r_rspValid <= 1'b1;
         r_rsp      <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
      end else if (r_rspValid && RSP_READY) begin
         r_rspValid <= 1'b0;
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   // Wait-state counter: restarts in SETUP and counts ACCESS cycles spent
   // waiting for the completer.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_waitCnt <= '0;
      end else if (r_state == APB_SETUP) begin
         r_waitCnt <= '0;
      end else if (r_state == APB_ACCESS && !PREADY) begin
         r_waitCnt <= r_waitCnt + CNT_W'(1);
      end
   end
`endif

   assign CMD_READY   = w_cmdReady;
   assign PWRITE      = r_cmd.write;
   assign PADDR       = r_cmd.addr;
   assign PWDATA      = r_cmd.wdata;
   assign RSP_VALID   = r_rspValid;
   assign RSP_RDATA   = r_rsp.rdata;
   assign RSP_ERR     = r_rsp.err;
   assign RSP_TIMEOUT = r_rsp.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed, table-driven bench for apb_master_bridge. The bench acts as the
// command source, the APB completer and the response consumer. Inputs are
// driven and outputs sampled on the falling clock edge. Build with
// APB_MASTER_TIMEOUT_EN defined to exercise the timeout abort.
module tb_apb_master_bridge;

   logic        PCLK;
   logic        PRESET;
   logic        CMD_VALID;
   logic        CMD_READY;
   logic        CMD_WRITE;
   logic [31:0] CMD_ADDR;
   logic [31:0] CMD_WDATA;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic [31:0] RSP_RDATA;
   logic        RSP_ERR;
   logic        RSP_TIMEOUT;
   logic        PSELx;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int compareCount = 0;
   int failCount    = 0;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] prdata;
      int          waits;
      logic        slverr;
      logic        pulseErr;
      logic [31:0] expRdata;
      logic        expErr;
      int          expLat;
   } vec_t;

   vec_t vecs[5];

   apb_master_bridge #(
      .ADDR_W(32),
      .DATA_W(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .PCLK(PCLK),
      .PRESET(PRESET),
      .CMD_VALID(CMD_VALID),
      .CMD_READY(CMD_READY),
      .CMD_WRITE(CMD_WRITE),
      .CMD_ADDR(CMD_ADDR),
      .CMD_WDATA(CMD_WDATA),
      .RSP_VALID(RSP_VALID),
      .RSP_READY(RSP_READY),
      .RSP_RDATA(RSP_RDATA),
      .RSP_ERR(RSP_ERR),
      .RSP_TIMEOUT(RSP_TIMEOUT),
      .PSELx(PSELx),
      .PENABLE(PENABLE),
      .PWRITE(PWRITE),
      .PADDR(PADDR),
      .PWDATA(PWDATA),
      .PRDATA(PRDATA),
      .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   // 10-time-unit clock.
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic sendCmd(input vec_t v);
      CMD_WRITE = v.write;
      CMD_ADDR  = v.addr;
      CMD_WDATA = v.wdata;
      CMD_VALID = 1'b1;
   endtask

   // Called on the falling edge where the command is offered and should be
   // taken at the next rising edge. Plays the completer until a response
   // appears or maxCycles elapse; lat counts cycles after the accept edge.
   task automatic runToResponse(input vec_t v, input int maxCycles,
                                output int lat, output int accessCnt, output bit done);
      checkOutput("cmdReadyAtIssue", 64'(CMD_READY), 64'd1);
      lat       = 0;
      accessCnt = 0;
      done      = 1'b0;
      while (!done && lat < maxCycles) begin
         @(negedge PCLK);
         lat++;
         CMD_VALID = 1'b0;
         if (RSP_VALID) begin
            done = 1'b1;
         end else if (PSELx && !PENABLE) begin
            checkOutput("setupAddr", 64'(PADDR), 64'(v.addr));
            checkOutput("setupWrite", 64'(PWRITE), 64'(v.write));
            if (v.write) checkOutput("setupWdata", 64'(PWDATA), 64'(v.wdata));
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
         end else if (PSELx && PENABLE) begin
            checkOutput("accessAddr", 64'(PADDR), 64'(v.addr));
            PREADY  = (accessCnt == v.waits);
            PSLVERR = (accessCnt == v.waits) ? v.slverr : v.pulseErr;
            PRDATA  = v.prdata;
            accessCnt++;
         end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
         end
      end
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
   endtask

   task automatic checkResponse(input vec_t v, input int lat, input int accessCnt, input bit done,
                                input int expAccess, input logic expTimeout);
      checkOutput("rspSeen", 64'(done), 64'd1);
      checkOutput("latency", 64'(lat), 64'(v.expLat));
      checkOutput("accessCycles", 64'(accessCnt), 64'(expAccess));
      checkOutput("rspRdata", 64'(RSP_RDATA), 64'(v.expRdata));
      checkOutput("rspErr", 64'(RSP_ERR), 64'(v.expErr));
      checkOutput("rspTimeout", 64'(RSP_TIMEOUT), 64'(expTimeout));
      checkOutput("pselIdleAtRsp", 64'(PSELx), 64'd0);
      checkOutput("cmdReadyWhileRsp", 64'(CMD_READY), 64'd0);
   endtask

   task automatic consumeResponse();
      RSP_READY = 1'b1;
      @(negedge PCLK);
      RSP_READY = 1'b0;
      checkOutput("rspCleared", 64'(RSP_VALID), 64'd0);
      checkOutput("readyAfterClear", 64'(CMD_READY), 64'd1);
   endtask

   task automatic applyStimulus(input vec_t v);
      int lat;
      int acc;
      bit done;
      sendCmd(v);
      runToResponse(v, 40, lat, acc, done);
      checkResponse(v, lat, acc, done, v.waits + 1, 1'b0);
      consumeResponse();
   endtask

   initial begin
      int lat;
      int acc;
      bit done;
      vec_t vA;
      vec_t vB;
      vec_t vR;
      vec_t vT;

      // write, read, error, error pulse in waits only, read at top address
      vecs[0] = '{1'b1, 32'h0000_0008, 32'h0000_1234, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'h0, 1'b0, 3};
      vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,         32'hCAFE_F00D, 2, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0, 5};
      vecs[2] = '{1'b1, 32'h0000_0010, 32'h0000_55AA, 32'h0,         1, 1'b1, 1'b0, 32'h0, 1'b1, 4};
      vecs[3] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1357_9BDF, 3, 1'b0, 1'b1, 32'h1357_9BDF, 1'b0, 6};
      vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFF, 0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 3};

      PRESET    = 1'b1;
      CMD_VALID = 1'b0;
      CMD_WRITE = 1'b0;
      CMD_ADDR  = '0;
      CMD_WDATA = '0;
      RSP_READY = 1'b0;
      PRDATA    = '0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      repeat (2) @(negedge PCLK);

      $display("[TB] reset state");
      checkOutput("rstPsel", 64'(PSELx), 64'd0);
      checkOutput("rstPenable", 64'(PENABLE), 64'd0);
      checkOutput("rstPwrite", 64'(PWRITE), 64'd0);
      checkOutput("rstPaddr", 64'(PADDR), 64'd0);
      checkOutput("rstPwdata", 64'(PWDATA), 64'd0);
      checkOutput("rstRspValid", 64'(RSP_VALID), 64'd0);
      checkOutput("rstRspRdata", 64'(RSP_RDATA), 64'd0);
      checkOutput("rstRspErr", 64'(RSP_ERR), 64'd0);
      checkOutput("rstRspTimeout", 64'(RSP_TIMEOUT), 64'd0);
      PRESET = 1'b0;
      @(negedge PCLK);
      checkOutput("idleCmdReady", 64'(CMD_READY), 64'd1);

      $display("[TB] vector table");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i]);
      end

      $display("[TB] back-pressure");
      vA = '{1'b0, 32'h0000_0100, 32'h0, 32'h0BAD_CAFE, 1, 1'b0, 1'b0, 32'h0BAD_CAFE, 1'b0, 4};
      vB = '{1'b1, 32'h0000_0200, 32'h8765_4321, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 3};
      sendCmd(vA);
      runToResponse(vA, 40, lat, acc, done);
      checkResponse(vA, lat, acc, done, 2, 1'b0);
      sendCmd(vB);
      for (int i = 0; i < 10; i++) begin
         checkOutput("bpCmdReady", 64'(CMD_READY), 64'd0);
         checkOutput("bpPsel", 64'(PSELx), 64'd0);
         checkOutput("bpRspHeld", 64'(RSP_VALID), 64'd1);
         @(negedge PCLK);
      end
      checkOutput("bpRdataHeld", 64'(RSP_RDATA), 64'h0BAD_CAFE);
      RSP_READY = 1'b1;
      checkOutput("bpNoBypass", 64'(CMD_READY), 64'd0);
      @(negedge PCLK);
      RSP_READY = 1'b0;
      checkOutput("bpCleared", 64'(RSP_VALID), 64'd0);
      runToResponse(vB, 40, lat, acc, done);
      checkResponse(vB, lat, acc, done, 1, 1'b0);
      consumeResponse();

      $display("[TB] reset mid-ACCESS");
      vR = '{1'b0, 32'h0000_0030, 32'h0, 32'h1111_2222, 5, 1'b0, 1'b0, 32'h0, 1'b0, 0};
      sendCmd(vR);
      @(negedge PCLK);
      CMD_VALID = 1'b0;
      checkOutput("mrSetup", 64'(PSELx && !PENABLE), 64'd1);
      @(negedge PCLK);
      checkOutput("mrAccess", 64'(PSELx && PENABLE), 64'd1);
      PRDATA  = 32'h1111_2222;
      PREADY  = 1'b1;
      PRESET  = 1'b1;
      @(negedge PCLK);
      PRESET  = 1'b0;
      PREADY  = 1'b0;
      checkOutput("mrPsel", 64'(PSELx), 64'd0);
      checkOutput("mrPenable", 64'(PENABLE), 64'd0);
      checkOutput("mrRspValid", 64'(RSP_VALID), 64'd0);
      checkOutput("mrPaddr", 64'(PADDR), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge PCLK);
         checkOutput("mrNoRsp", 64'(RSP_VALID), 64'd0);
         checkOutput("mrBusIdle", 64'(PSELx), 64'd0);
      end
      applyStimulus(vecs[1]);

`ifdef APB_MASTER_TIMEOUT_EN
      $display("[TB] timeout abort");
      vT = '{1'b0, 32'h0000_0040, 32'h0, 32'hA5A5_A5A5, 1000, 1'b0, 1'b0, 32'h0, 1'b1, 6};
      sendCmd(vT);
      runToResponse(vT, 40, lat, acc, done);
      checkResponse(vT, lat, acc, done, 4, 1'b1);
      consumeResponse();
      applyStimulus(vecs[0]);
`else
      $display("[TB] no timeout: ACCESS persists");
      vT = '{1'b0, 32'h0000_0040, 32'h0, 32'hA5A5_A5A5, 100000, 1'b0, 1'b0, 32'h0, 1'b0, 0};
      sendCmd(vT);
      runToResponse(vT, 1001, lat, acc, done);
      checkOutput("ntNoRsp", 64'(done), 64'd0);
      checkOutput("ntAccessCycles", 64'(acc), 64'd1000);
      checkOutput("ntStillAccess", 64'(PSELx && PENABLE), 64'd1);
      checkOutput("ntTimeoutFlag", 64'(RSP_TIMEOUT), 64'd0);
      PRESET = 1'b1;
      @(negedge PCLK);
      PRESET = 1'b0;
      checkOutput("ntRecovered", 64'(PSELx), 64'd0);
      applyStimulus(vecs[0]);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
